// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide path: operator encoding and sequencer states.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_BUSY  = 2'b01,
        SEQ_DRAIN = 2'b10,
        SEQ_RESP  = 2'b11
    } md_seq_state_e;

endpackage

// File: rtl/ibex_multdiv_sequencer_if.sv
// Request, datapath and response signals of the multdiv sequencer.
// slave is the sequencer's view; master is the surrounding core/datapath view.
interface ibex_multdiv_sequencer_if;
    import ibex_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    md_op_e      req_operator_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        kill_i;

    logic        md_mult_en_o;
    logic        md_div_en_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic [31:0] md_result_i;
    logic        md_valid_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, kill_i,
        input  md_result_i, md_valid_i, rsp_ready_i,
        output req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
        output md_op_a_o, md_op_b_o, rsp_valid_o, rsp_result_o, busy_o
    );

    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, kill_i,
        output md_result_i, md_valid_i, rsp_ready_i,
        input  req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
        input  md_op_a_o, md_op_b_o, rsp_valid_o, rsp_result_o, busy_o
    );

endinterface

// File: rtl/ibex_multdiv_sequencer.sv
// Sequences one mul/div request at a time through the datapath, with a one-entry result cache.
// Latency: miss -> response the cycle after md_valid_i; hit -> response one cycle after accept.
// Backpressure: holds the response until rsp_ready_i; accepts new requests only when idle.
module ibex_multdiv_sequencer
    import ibex_pkg::*;
#(
    parameter bit ResultCache = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ibex_multdiv_sequencer_if.slave  bus
);

    md_seq_state_e state_q, state_d;
    md_op_e        op_q, op_d;
    logic [1:0]    sm_q, sm_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic          mult_en_q, mult_en_d, div_en_q, div_en_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic          cache_valid_q, cache_valid_d;
    md_op_e        cache_op_q, cache_op_d;
    logic [1:0]    cache_sm_q, cache_sm_d;
    logic [31:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d, cache_data_q, cache_data_d;

    logic accept, hit, req_is_mult;

    assign accept      = bus.req_valid_i & (state_q == SEQ_IDLE) & ~bus.kill_i;
    assign req_is_mult = (bus.req_operator_i == MD_OP_MULL) | (bus.req_operator_i == MD_OP_MULH);
    assign hit         = ResultCache & cache_valid_q
                       & (cache_op_q == bus.req_operator_i)
                       & (cache_sm_q == bus.req_signed_mode_i)
                       & (cache_a_q  == bus.req_op_a_i)
                       & (cache_b_q  == bus.req_op_b_i);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sm_d          = sm_q;
        a_d           = a_q;
        b_d           = b_q;
        mult_en_d     = mult_en_q;
        div_en_d      = div_en_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        cache_valid_d = cache_valid_q;
        cache_op_d    = cache_op_q;
        cache_sm_d    = cache_sm_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_data_d  = cache_data_q;

        unique case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    op_d = bus.req_operator_i;
                    sm_d = bus.req_signed_mode_i;
                    a_d  = bus.req_op_a_i;
                    b_d  = bus.req_op_b_i;
                    if (hit) begin
                        state_d      = SEQ_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = cache_data_q;
                    end else begin
                        state_d   = SEQ_BUSY;
                        mult_en_d = req_is_mult;
                        div_en_d  = ~req_is_mult;
                    end
                end
            end
            SEQ_BUSY: begin
                if (bus.md_valid_i) begin
                    mult_en_d = 1'b0;
                    div_en_d  = 1'b0;
                    if (bus.kill_i) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        state_d       = SEQ_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_result_d  = bus.md_result_i;
                        cache_valid_d = 1'b1;
                        cache_op_d    = op_q;
                        cache_sm_d    = sm_q;
                        cache_a_d     = a_q;
                        cache_b_d     = b_q;
                        cache_data_d  = bus.md_result_i;
                    end
                end else if (bus.kill_i) begin
                    // Keep the enables up so the datapath runs to completion and returns to idle.
                    state_d = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (bus.md_valid_i) begin
                    state_d   = SEQ_IDLE;
                    mult_en_d = 1'b0;
                    div_en_d  = 1'b0;
                end
            end
            SEQ_RESP: begin
                if (bus.rsp_ready_i || bus.kill_i) begin
                    state_d     = SEQ_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SEQ_IDLE;
            op_q          <= MD_OP_MULL;
            sm_q          <= 2'b00;
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'h0;
            cache_valid_q <= 1'b0;
            cache_op_q    <= MD_OP_MULL;
            cache_sm_q    <= 2'b00;
            cache_a_q     <= 32'h0;
            cache_b_q     <= 32'h0;
            cache_data_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sm_q          <= sm_d;
            a_q           <= a_d;
            b_q           <= b_d;
            mult_en_q     <= mult_en_d;
            div_en_q      <= div_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            cache_valid_q <= cache_valid_d;
            cache_op_q    <= cache_op_d;
            cache_sm_q    <= cache_sm_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_data_q  <= cache_data_d;
        end
    end

    assign bus.req_ready_o      = (state_q == SEQ_IDLE);
    assign bus.busy_o           = (state_q != SEQ_IDLE);
    assign bus.md_mult_en_o     = mult_en_q;
    assign bus.md_div_en_o      = div_en_q;
    assign bus.md_operator_o    = op_q;
    assign bus.md_signed_mode_o = sm_q;
    assign bus.md_op_a_o        = a_q;
    assign bus.md_op_b_o        = b_q;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_result_o     = rsp_result_q;

    a_state_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(state_q) && (state_q inside {SEQ_IDLE, SEQ_BUSY, SEQ_DRAIN, SEQ_RESP}));

    a_en_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mult_en_q && div_en_q));

endmodule

// File: doc/ibex_multdiv_sequencer.md
IBEX_MULTDIV_SEQUENCER -- requirements
Module: ibex_multdiv_sequencer

Interface
REQ-001 ResultCache, 1'b1, SHALL enable the one-entry last-result cache when 1; when 0 every request SHALL issue to the datapath.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 req_valid_i  input  1  request from ID stage is valid.
REQ-005 req_ready_o  output  1  sequencer accepts a request this cycle.
REQ-006 req_operator_i  input  md_op_e  MD_OP_MULL/MULH/DIV/REM.
REQ-007 req_signed_mode_i  input  2  bit0 = operand A signed, bit1 = operand B signed.
REQ-008 req_op_a_i, req_op_b_i  input  32 each  operands.
REQ-009 kill_i  input  1  flush; discards the in-flight or pending result.
REQ-010 md_mult_en_o, md_div_en_o  output  1 each  enables to the multiply/divide datapath.
REQ-011 md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o  output  md_op_e/2/32/32  registered operands to the datapath.
REQ-012 md_result_i  input  32  datapath result; md_valid_i  input  1  datapath done.
REQ-013 rsp_valid_o  output  1; rsp_ready_i  input  1; rsp_result_o  output  32  response to writeback.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be SEQ_IDLE, SEQ_BUSY, SEQ_DRAIN, SEQ_RESP.
REQ-016 req_ready_o SHALL equal (state==SEQ_IDLE); accept = req_valid_i & req_ready_o & ~kill_i.
REQ-017 On accept the operator, signed mode and operands SHALL be registered onto md_*_o, held stable until return to SEQ_IDLE.
REQ-018 Cache hit = ResultCache & cache_valid & operator, signed mode, op_a, op_b all equal to the stored tag; on hit, IDLE->SEQ_RESP with the cached value and no enable asserted.
REQ-019 On miss, IDLE->SEQ_BUSY; in SEQ_BUSY and SEQ_DRAIN md_mult_en_o = 1 for MULL/MULH, md_div_en_o = 1 for DIV/REM; both SHALL be 0 in SEQ_IDLE and SEQ_RESP; never both 1.
REQ-020 SEQ_BUSY with md_valid_i: capture md_result_i into the response register, write cache tag/data with cache_valid=1, go to SEQ_RESP.
REQ-021 Latency: miss response valid on the cycle after md_valid_i; hit response valid one cycle after accept.
REQ-022 SEQ_RESP: rsp_valid_o = 1 and rsp_result_o SHALL be stable until rsp_ready_i; on rsp_valid_o & rsp_ready_i -> SEQ_IDLE.
REQ-023 kill_i in SEQ_BUSY (without md_valid_i in the same cycle) -> SEQ_DRAIN; enables SHALL stay asserted until md_valid_i, then SEQ_IDLE with the result discarded and the cache unchanged, so the datapath FSMs always return to their idle state.
REQ-024 kill_i in SEQ_BUSY coincident with md_valid_i -> SEQ_IDLE, result discarded, cache unchanged.
REQ-025 kill_i in SEQ_RESP -> SEQ_IDLE, rsp_valid_o deasserted the next cycle; kill_i in SEQ_IDLE blocks acceptance that cycle.
REQ-026 kill_i SHALL NOT clear a valid cache entry; only reset SHALL clear cache_valid.
REQ-027 rsp_valid_o SHALL be 0 in SEQ_DRAIN; no response is produced for a killed request.

Reset
REQ-028 On rst_ni low: state = SEQ_IDLE, cache_valid = 0, all md_*_o, rsp_result_o and cache data/tag = 0, rsp_valid_o = 0, busy_o = 0, req_ready_o = 1 after release.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no response; the datapath is reset by the same rst_ni.

Structure
REQ-030 md_seq_state_e (4 states) SHALL live in ibex_pkg alongside md_op_e; no new constants.
REQ-031 No sub-module; cache compare and FSM are in-module, with a single always_ff holding all registers.
REQ-032 An assertion SHALL check the state is known/valid and that md_mult_en_o & md_div_en_o never both assert.

Verification
REQ-033 MULL 7 x 6, unsigned -> one response 42 (0x0000002A), md_div_en_o never high.
REQ-034 MULH signed 0xFFFFFFFF x 0xFFFFFFFF -> response 0x00000000; an identical second request -> hit, response 1 cycle after accept, enables stay 0.
REQ-035 DIV 100 / 0 -> 0xFFFFFFFF; REM signed 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
REQ-036 kill_i pulsed 5 cycles into DIV 100 / 7 -> SEQ_DRAIN, div_en held until md_valid_i, no rsp_valid_o, req_ready_o low until drain ends; next request DIV 100 / 7 is a miss returning 14.
REQ-037 rsp_ready_i held low 10 cycles on a MULL result -> rsp_valid_o and rsp_result_o constant, req_ready_o = 0 throughout.
REQ-038 Reset asserted in SEQ_BUSY -> all outputs at reset values; first post-reset request is a cache miss.
